// File: rtl/lcd_pkg.sv
// Shared definitions for the 16x2 character LCD blocks.
// Holds the display geometry, the frame-buffer width, the fill character,
// the write payload struct and the frame-buffer owner FSM state encoding.
package lcd_pkg;

    localparam int unsigned LCD_COLS  = 16;
    localparam int unsigned LCD_ROWS  = 2;
    localparam int unsigned LCD_CELLS = 32;
    localparam int unsigned FB_W      = 256;
    localparam int unsigned CELL_W    = 5;
    localparam int unsigned CHAR_W    = 8;

    localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

    // One character write: p[4] is the line, p[3:0] the column
    typedef struct packed {
        logic [CELL_W-1:0] addr;
        logic [CHAR_W-1:0] ch;
    } lcd_wr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        CLEAR = 2'd2
    } lcd_state_e;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker for shared LCD resources.
// Ports:
//   req  - per-requester request vector
//   ptr  - index where the search starts (wraps modulo NUM_REQ)
//   win  - one-hot winner, all zero when no request
//   idx  - binary index of the winner, zero when no request
module lcd_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // First active request at or after ptr, wrapping around
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/lcd_fb_arbiter.sv
// Frame-buffer owner for the 16x2 character LCD.
// Serialises single-character writes from NUM_REQ clients via round-robin
// and offers a bulk clear that sweeps all 32 cells to CLEAR_CHAR.
// Ports:
//   iCLK, iRST_N - clock, synchronous active-low reset
//   iREQ         - per-requester write request, held until granted
//   iADDR        - per-requester 5-bit cell index, packed 5 bits per client
//   iCHAR        - per-requester character code, packed 8 bits per client
//   iCLR         - clear request, only looked at in IDLE
//   oGNT         - one-hot grant pulse
//   oBUSY        - high while a clear sweep runs
//   oCHG         - pulse after every completed frame-buffer change
//   oFB          - frame buffer, cell p at oFB[8p+7:8p]
module lcd_fb_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned       NUM_REQ    = 4,
    parameter logic [CHAR_W-1:0] CLEAR_CHAR = CHAR_SPACE
) (
    input  logic                      iCLK,
    input  logic                      iRST_N,
    input  logic [NUM_REQ-1:0]        iREQ,
    input  logic [CELL_W*NUM_REQ-1:0] iADDR,
    input  logic [CHAR_W*NUM_REQ-1:0] iCHAR,
    input  logic                      iCLR,
    output logic [NUM_REQ-1:0]        oGNT,
    output logic                      oBUSY,
    output logic                      oCHG,
    output logic [FB_W-1:0]           oFB
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    lcd_state_e        state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [CELL_W-1:0] clr_idx, clr_idx_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic              busy_n, chg_n;
    logic [FB_W-1:0]   fb_n;

    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;
    lcd_wr_t            wr [NUM_REQ];

    // Unpack the flat per-client buses
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign wr[g].addr = iADDR[CELL_W*g +: CELL_W];
        assign wr[g].ch   = iCHAR[CHAR_W*g +: CHAR_W];
    end

    lcd_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (iREQ),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx)
    );

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state   <= IDLE;
            ptr     <= '0;
            clr_idx <= '0;
            oGNT    <= '0;
            oBUSY   <= 1'b0;
            oCHG    <= 1'b0;
            oFB     <= {LCD_CELLS{CLEAR_CHAR}};
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            clr_idx <= clr_idx_n;
            oGNT    <= gnt_n;
            oBUSY   <= busy_n;
            oCHG    <= chg_n;
            oFB     <= fb_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        clr_idx_n = clr_idx;
        gnt_n     = '0;
        busy_n    = oBUSY;
        chg_n     = 1'b0;
        fb_n      = oFB;

        case (state)
            IDLE: begin
                // Clear wins over any pending write
                if (iCLR) begin
                    state_n   = CLEAR;
                    busy_n    = 1'b1;
                    clr_idx_n = '0;
                end else if (|iREQ) begin
                    state_n = ACK;
                    gnt_n   = pick_win;
                    chg_n   = 1'b1;
                    fb_n[{wr[pick_idx].addr, 3'b000} +: CHAR_W] = wr[pick_idx].ch;
                    ptr_n   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : pick_idx + IDX_W'(1);
                end
            end

            // Requests are not sampled here, so a held iREQ cannot double-grant
            ACK: begin
                state_n = IDLE;
            end

            CLEAR: begin
                fb_n[{clr_idx, 3'b000} +: CHAR_W] = CLEAR_CHAR;
                clr_idx_n = clr_idx + CELL_W'(1);
                if (clr_idx == CELL_W'(LCD_CELLS - 1)) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    chg_n   = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed self-checking bench for lcd_fb_arbiter (NUM_REQ = 4).
module tb_lcd_fb_arbiter;

    localparam int unsigned NR = 4;

    logic             iCLK;
    logic             iRST_N;
    logic [NR-1:0]    iREQ;
    logic [5*NR-1:0]  iADDR;
    logic [8*NR-1:0]  iCHAR;
    logic             iCLR;
    logic [NR-1:0]    oGNT;
    logic             oBUSY;
    logic             oCHG;
    logic [255:0]     oFB;

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_fb;
    logic [255:0] all_space;
    logic [255:0] all_z;
    int           busy_cnt;
    logic         busy_done;
    logic [3:0]   exp_gnt;

    lcd_fb_arbiter #(
        .NUM_REQ    (NR),
        .CLEAR_CHAR (8'h20)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iREQ   (iREQ),
        .iADDR  (iADDR),
        .iCHAR  (iCHAR),
        .iCLR   (iCLR),
        .oGNT   (oGNT),
        .oBUSY  (oBUSY),
        .oCHG   (oCHG),
        .oFB    (oFB)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic set_slot(input int k, input logic [4:0] a, input logic [7:0] c);
        iADDR[5*k +: 5] = a;
        iCHAR[8*k +: 8] = c;
    endtask

    task automatic set_cell(input logic [4:0] a, input logic [7:0] c);
        exp_fb[{a, 3'b000} +: 8] = c;
    endtask

    initial begin
        all_space = {32{8'h20}};
        all_z     = {32{8'h5A}};
        iRST_N = 1'b0;
        iREQ   = '0;
        iADDR  = '0;
        iCHAR  = '0;
        iCLR   = 1'b0;
        repeat (3) tick();
        iRST_N = 1'b1;

        // Reset state
        check("reset_fb", oFB, all_space);
        check("reset_gnt", 256'(oGNT), 256'(0));
        check("reset_busy", 256'(oBUSY), 256'(0));
        check("reset_chg", 256'(oCHG), 256'(0));
        exp_fb = all_space;

        // Single write from req0 to line 1 column 0
        set_slot(0, 5'h10, 8'h41);
        iREQ = 4'b0001;
        tick();
        set_cell(5'h10, 8'h41);
        check("single_gnt", 256'(oGNT), 256'(4'b0001));
        check("single_chg", 256'(oCHG), 256'(1));
        check("single_cell", 256'(oFB[135:128]), 256'(8'h41));
        iREQ = 4'b0000;
        tick();
        check("single_gnt_off", 256'(oGNT), 256'(0));
        check("single_chg_off", 256'(oCHG), 256'(0));
        check("single_fb", oFB, exp_fb);

        // Lone requester 3 wins with pointer at 1; pointer then wraps to 0
        set_slot(3, 5'h1F, 8'h42);
        iREQ = 4'b1000;
        tick();
        set_cell(5'h1F, 8'h42);
        check("lone_gnt", 256'(oGNT), 256'(4'b1000));
        iREQ = 4'b0000;
        tick();
        check("lone_fb", oFB, exp_fb);

        // Contention: req0..2 held through every ACK
        set_slot(0, 5'h00, 8'h61);
        set_slot(1, 5'h01, 8'h62);
        set_slot(2, 5'h02, 8'h63);
        iREQ = 4'b0111;
        for (int g = 0; g < 6; g++) begin
            tick();
            exp_gnt = 4'b0001 << (g % 3);
            check($sformatf("cont_gnt_%0d", g), 256'(oGNT), 256'(exp_gnt));
            check($sformatf("cont_chg_%0d", g), 256'(oCHG), 256'(1));
            tick();
            check($sformatf("cont_ack_%0d", g), 256'(oGNT), 256'(0));
        end
        iREQ = 4'b0000;
        set_cell(5'h00, 8'h61);
        set_cell(5'h01, 8'h62);
        set_cell(5'h02, 8'h63);
        check("cont_fb", oFB, exp_fb);

        // Clear and req3 together: clear wins, req3 waits until oBUSY falls
        set_slot(3, 5'h05, 8'h51);
        iREQ = 4'b1000;
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        check("clr_busy_rise", 256'(oBUSY), 256'(1));
        check("clr_no_gnt", 256'(oGNT), 256'(0));
        busy_cnt  = 1;
        busy_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_done) begin
                tick();
                if (oBUSY) begin
                    busy_cnt++;
                    if (oGNT != 4'b0000) check("clr_gnt_during", 256'(oGNT), 256'(0));
                end else begin
                    busy_done = 1'b1;
                end
            end
        end
        check("clr_busy_len", 256'(busy_cnt), 256'(32));
        check("clr_fb", oFB, all_space);
        check("clr_chg", 256'(oCHG), 256'(1));
        check("clr_gnt_end", 256'(oGNT), 256'(0));
        tick();
        exp_fb = all_space;
        set_cell(5'h05, 8'h51);
        check("clr_req3_gnt", 256'(oGNT), 256'(4'b1000));
        check("clr_req3_fb", oFB, exp_fb);
        iREQ = 4'b0000;
        tick();

        // Fill every cell with 'Z'
        for (int c = 0; c < 32; c++) begin
            set_slot(0, 5'(c), 8'h5A);
            iREQ = 4'b0001;
            tick();
            iREQ = 4'b0000;
            tick();
        end
        check("fill_z_fb", oFB, all_z);

        // Reset during clear cycle 10
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        repeat (10) tick();
        exp_fb = all_z;
        for (int c = 0; c < 10; c++) set_cell(5'(c), 8'h20);
        check("midclr_partial_fb", oFB, exp_fb);
        check("midclr_busy", 256'(oBUSY), 256'(1));
        iRST_N = 1'b0;
        tick();
        check("midclr_rst_fb", oFB, all_space);
        check("midclr_rst_busy", 256'(oBUSY), 256'(0));
        check("midclr_rst_chg", 256'(oCHG), 256'(0));
        iRST_N = 1'b1;
        tick();
        check("post_rst_busy", 256'(oBUSY), 256'(0));
        exp_fb = all_space;

        // Move pointer to 1 with a req0 write
        set_slot(0, 5'h00, 8'h30);
        iREQ = 4'b0001;
        tick();
        iREQ = 4'b0000;
        tick();
        set_cell(5'h00, 8'h30);

        // Same-cell race: req1 'X' then req2 'Y' to cell 3
        set_slot(1, 5'h03, 8'h58);
        set_slot(2, 5'h03, 8'h59);
        iREQ = 4'b0110;
        tick();
        check("race_gnt1", 256'(oGNT), 256'(4'b0010));
        check("race_cell_x", 256'(oFB[31:24]), 256'(8'h58));
        iREQ = 4'b0100;
        tick();
        check("race_ack", 256'(oGNT), 256'(0));
        tick();
        check("race_gnt2", 256'(oGNT), 256'(4'b0100));
        iREQ = 4'b0000;
        tick();
        set_cell(5'h03, 8'h59);
        check("race_cell_y", 256'(oFB[31:24]), 256'(8'h59));
        check("race_fb", oFB, exp_fb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_fb_arbiter.md
# lcd_fb_arbiter

Shared frame-buffer owner for the 16x2 character LCD. Up to NUM_REQ independent clients write single characters to display cells through a req/grant handshake. A round-robin arbiter serialises the writes into one registered 256-bit frame buffer. That buffer drives the iFB input of LCD_MODULE directly. The block also provides a bulk clear that sweeps all 32 cells to a fill character.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CLEAR_CHAR, 8'h20, fill character for reset and clear

Ports:
- iCLK  in  1  system clock (CLOCK_50 domain)
- iRST_N  in  1  reset, synchronous, active-low
- iREQ  in  NUM_REQ  per-requester write request, held until granted
- iADDR  in  5*NUM_REQ  per-requester cell index p[4:0]; p[4] is the line, p[3:0] is the column
- iCHAR  in  8*NUM_REQ  per-requester character code
- iCLR  in  1  clear request, sampled only in IDLE
- oGNT  out  NUM_REQ  one-hot grant, 1-cycle pulse
- oBUSY  out  1  high while a clear sweep runs
- oCHG  out  1  1-cycle pulse after every completed frame-buffer change
- oFB  out  256  frame buffer; cell p occupies oFB[8p+7:8p]

## Operation
- Reset values (iRST_N low at a clock edge): state IDLE, RR pointer 0, oGNT 0, oBUSY 0, oCHG 0, every oFB byte set to CLEAR_CHAR, clear index 0.
- The FSM has three states: IDLE, ACK, CLEAR.
- IDLE, with iCLR high: go to CLEAR, oBUSY <= 1, clear index <= 0. iCLR has priority over all requests; pending requests are not granted.
- IDLE, with any iREQ high: pick winner k by round-robin. Then go to ACK, oGNT[k] <= 1, oFB cell iADDR[k] <= iCHAR[k], oCHG <= 1, pointer <= (k+1) mod NUM_REQ.
- Round-robin search starts at the pointer index and wraps. A lone requester is always granted regardless of pointer.
- ACK: oGNT <= 0, oCHG <= 0, return to IDLE. No request is sampled in ACK, so a requester still holding iREQ during its grant cycle is never double-granted.
- Requesters drop iREQ, or present their next write, in the cycle after they see oGNT.
- CLEAR: at each edge, write CLEAR_CHAR to the cell at the clear index and increment the index.
  - At the edge that writes cell 31: oBUSY <= 0, oCHG <= 1, go to IDLE.
  - iREQ and iCLR are ignored during CLEAR.
- Address arithmetic: the 5-bit index covers exactly 32 cells, so there are no out-of-range addresses. The clear index is 5 bits and wraps to 0 on completion.
- Two requesters targeting the same cell: writes apply in grant order, and the last grant wins.
- Reset asserted mid-CLEAR or mid-ACK: the whole frame buffer returns to CLEAR_CHAR and all outputs return to their reset values on that edge.

## Timing
- Write latency: iREQ high before edge E (state IDLE) gives oGNT high and the new oFB cell visible after E. oGNT is low after E+1.
- Uncontested throughput: one write per 2 cycles. With N requesters all active, each is granted once every 2N cycles.
- Clear: iCLR sampled at E; cells 0..31 are written at E+1..E+32. oBUSY is high from E to E+32; oCHG pulses after E+32.
- A clear occupies the block for 33 cycles, including the sampling edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package lcd_pkg holds:
  - LCD_COLS=16, LCD_ROWS=2, LCD_CELLS=32, FB_W=256, CHAR_SPACE=8'h20
  - the FSM state enum {IDLE, ACK, CLEAR}
- Sub-module lcd_rr_pick: combinational round-robin picker with inputs req[NUM_REQ] and ptr, and outputs one-hot win plus an index. It is reusable for other shared LCD resources.
- The top level holds the FSM, pointer, clear counter and frame-buffer registers.

## Test plan
- Reset check: release iRST_N. Require oFB = {32{8'h20}}, oGNT = 0, oBUSY = 0, oCHG = 0.
- Single write: req0 with iADDR=5'h10 and iCHAR=8'h41. Require oGNT = 4'b0001 for exactly 1 cycle, oFB[135:128] = 8'h41, and one oCHG pulse.
- Contention: req0, req1 and req2 held continuously. Require grants in order 0, 1, 2, 0, 1, 2 at 2-cycle spacing, with no double grant while iREQ is held through ACK.
- Clear vs. request: iCLR and req3 asserted together in IDLE.
  - Require oBUSY high for 32 cycles and all cells 8'h20.
  - Require req3 to be granted only after oBUSY falls.
- Reset mid-clear: assert iRST_N low during CLEAR cycle 10, after writing 'Z' to every cell beforehand. Require the full buffer 8'h20 and oBUSY = 0 on the next edge.
- Same-cell race: req1 writes 'X' and req2 writes 'Y' to cell 3 with pointer = 1. Require the final oFB[31:24] = 8'h59 ('Y').
